// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_C = 2'd1,
    GNT_D = 2'd2,
    DONE  = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWN_C = 1'b0,
    OWN_D = 1'b1
  } arb_owner_e;

  localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/arb_burst_ctr.sv
// Saturating count of consecutive CPU grants taken while DMA waits; decides
// when the DMA engine must win the next arbitration.
module arb_burst_ctr #(
  parameter int unsigned BURST_MAX = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic cpu_req_i,
  input  logic dma_req_i,
  input  logic grant_c_i,
  input  logic grant_d_i,
  output logic grant_d_o
);

  localparam int unsigned CW = $clog2(BURST_MAX + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          at_max;

  assign at_max    = (cnt_q == CW'(BURST_MAX));
  assign grant_d_o = dma_req_i & (~cpu_req_i | at_max);

  always_comb begin
    cnt_d = cnt_q;
    if (grant_d_i) begin
      cnt_d = '0;
    end else if (grant_c_i) begin
      if (!dma_req_i)  cnt_d = '0;
      else if (!at_max) cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port (CPU / DMA) arbiter for a single-port data memory with req/ack handshake.
// Optional watchdog enabled by defining DMEM_ARB_TIMEOUT_EN.
//
// state | meaning
// IDLE  | no access in flight; arbitrate on the current requests
// GNT_C | CPU access on the memory; after mem ack, one extra cycle with owner ack high
// GNT_D | DMA access on the memory; same completion cycle as GNT_C
// DONE  | bubble so the requester can drop or renew its request
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned BURST_MAX = 4,
  parameter int unsigned TIMEOUT   = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic [DATA_W-1:0] cpu_rdata_o,
  output logic              cpu_ack_o,
  output logic              cpu_stall_o,
  input  logic              dma_req_i,
  input  logic              dma_we_i,
  input  logic [ADDR_W-1:0] dma_addr_i,
  input  logic [DATA_W-1:0] dma_wdata_i,
  output logic [DATA_W-1:0] dma_rdata_o,
  output logic              dma_ack_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i,
  output logic              err_o
);

  if (BURST_MAX < 1 || TIMEOUT < 2) begin : g_param_check
    $error("dmem_arbiter: BURST_MAX must be >= 1 and TIMEOUT >= 2");
  end

  arb_state_e        state_q, state_d;
  logic              mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d, dma_rdata_q, dma_rdata_d;
  logic              cpu_ack_q, cpu_ack_d, dma_ack_q, dma_ack_d;
  logic              grant_d_w, take_c, take_d, finish;
  logic [DATA_W-1:0] fin_data;
  arb_owner_e        owner;

`ifdef DMEM_ARB_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wait_q, wait_d;
  logic          err_q, err_d;
`endif

  arb_burst_ctr #(.BURST_MAX(BURST_MAX)) u_burst_ctr (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .cpu_req_i (cpu_req_i),
    .dma_req_i (dma_req_i),
    .grant_c_i (take_c),
    .grant_d_i (take_d),
    .grant_d_o (grant_d_w)
  );

  assign take_d = (state_q == IDLE) & grant_d_w;
  assign take_c = (state_q == IDLE) & cpu_req_i & ~grant_d_w;
  assign owner  = (state_q == GNT_D) ? OWN_D : OWN_C;

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    dma_rdata_d = dma_rdata_q;
    cpu_ack_d   = 1'b0;
    dma_ack_d   = 1'b0;
    finish      = 1'b0;
    fin_data    = mem_rdata_i;
`ifdef DMEM_ARB_TIMEOUT_EN
    wait_d      = wait_q;
    err_d       = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (take_d) begin
          state_d     = GNT_D;
          mem_req_d   = 1'b1;
          mem_we_d    = dma_we_i;
          mem_addr_d  = dma_addr_i;
          mem_wdata_d = dma_wdata_i;
        end else if (take_c) begin
          state_d     = GNT_C;
          mem_req_d   = 1'b1;
          mem_we_d    = cpu_we_i;
          mem_addr_d  = cpu_addr_i;
          mem_wdata_d = cpu_wdata_i;
        end
`ifdef DMEM_ARB_TIMEOUT_EN
        // Loaded so the timeout ack lands on the TIMEOUT-th cycle after grant.
        wait_d = TW'(TIMEOUT - 2);
`endif
      end
      GNT_C, GNT_D: begin
        // Owner ack is high this cycle: completion already taken, leave the grant.
        if (cpu_ack_q | dma_ack_q) begin
          state_d = DONE;
        end else if (mem_ack_i) begin
          finish = 1'b1;
`ifdef DMEM_ARB_TIMEOUT_EN
        end else if (wait_q == '0) begin
          finish   = 1'b1;
          fin_data = DATA_W'(TIMEOUT_DATA);
          err_d    = 1'b1;
        end else begin
          wait_d = wait_q - TW'(1);
`endif
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (finish) begin
      mem_req_d = 1'b0;
      if (owner == OWN_D) begin
        dma_rdata_d = fin_data;
        dma_ack_d   = 1'b1;
      end else begin
        cpu_rdata_d = fin_data;
        cpu_ack_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
      cpu_ack_q   <= 1'b0;
      dma_ack_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
      cpu_ack_q   <= cpu_ack_d;
      dma_ack_q   <= dma_ack_d;
    end
  end

`ifdef DMEM_ARB_TIMEOUT_EN
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wait_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wait_q <= wait_d;
      err_q  <= err_d;
    end
  end
  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign cpu_rdata_o = cpu_rdata_q;
  assign dma_rdata_o = dma_rdata_q;
  assign cpu_ack_o   = cpu_ack_q;
  assign dma_ack_o   = dma_ack_q;
  assign cpu_stall_o = cpu_req_i & ~cpu_ack_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter; inputs driven and outputs sampled on negedge.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_i = 1'b0;
  logic        cpu_req_i = 1'b0, cpu_we_i = 1'b0;
  logic [31:0] cpu_addr_i = '0, cpu_wdata_i = '0;
  logic [31:0] cpu_rdata_o;
  logic        cpu_ack_o, cpu_stall_o;
  logic        dma_req_i = 1'b0, dma_we_i = 1'b0;
  logic [31:0] dma_addr_i = '0, dma_wdata_i = '0;
  logic [31:0] dma_rdata_o;
  logic        dma_ack_o;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [31:0] mem_rdata_i = '0;
  logic        mem_ack_i = 1'b0;
  logic        err_o;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .BURST_MAX(4), .TIMEOUT(8)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
    .cpu_wdata_i(cpu_wdata_i), .cpu_rdata_o(cpu_rdata_o), .cpu_ack_o(cpu_ack_o),
    .cpu_stall_o(cpu_stall_o),
    .dma_req_i(dma_req_i), .dma_we_i(dma_we_i), .dma_addr_i(dma_addr_i),
    .dma_wdata_i(dma_wdata_i), .dma_rdata_o(dma_rdata_o), .dma_ack_o(dma_ack_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i),
    .err_o(err_o)
  );

  task automatic test_reset();
    rst_i = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++; if (mem_req_o !== 1'b0) begin tests_failed++; $display("FAIL reset_mem_req: got %b want 0", mem_req_o); end
    tests_run++; if (mem_we_o !== 1'b0) begin tests_failed++; $display("FAIL reset_mem_we: got %b want 0", mem_we_o); end
    tests_run++; if (mem_addr_o !== 32'h0) begin tests_failed++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr_o); end
    tests_run++; if (mem_wdata_o !== 32'h0) begin tests_failed++; $display("FAIL reset_mem_wdata: got %h want 0", mem_wdata_o); end
    tests_run++; if ({cpu_ack_o, dma_ack_o} !== 2'b00) begin tests_failed++; $display("FAIL reset_acks: got %b want 00", {cpu_ack_o, dma_ack_o}); end
    tests_run++; if (cpu_rdata_o !== 32'h0) begin tests_failed++; $display("FAIL reset_cpu_rdata: got %h want 0", cpu_rdata_o); end
    tests_run++; if (dma_rdata_o !== 32'h0) begin tests_failed++; $display("FAIL reset_dma_rdata: got %h want 0", dma_rdata_o); end
    tests_run++; if (err_o !== 1'b0) begin tests_failed++; $display("FAIL reset_err: got %b want 0", err_o); end
    rst_i = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_cpu_read();
    cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h10; cpu_wdata_i = 32'hFFFF_FFFF;
    #1;
    tests_run++; if (cpu_stall_o !== 1'b1) begin tests_failed++; $display("FAIL cpu_stall_req: got %b want 1", cpu_stall_o); end
    @(negedge clk);
    tests_run++; if (mem_req_o !== 1'b1) begin tests_failed++; $display("FAIL cpu_mem_req: got %b want 1", mem_req_o); end
    tests_run++; if (mem_addr_o !== 32'h10) begin tests_failed++; $display("FAIL cpu_mem_addr: got %h want 10", mem_addr_o); end
    tests_run++; if (mem_we_o !== 1'b0) begin tests_failed++; $display("FAIL cpu_mem_we: got %b want 0", mem_we_o); end
    @(negedge clk);
    tests_run++; if ({mem_req_o, cpu_stall_o, cpu_ack_o} !== 3'b110) begin tests_failed++; $display("FAIL cpu_wait: got %b want 110", {mem_req_o, cpu_stall_o, cpu_ack_o}); end
    @(negedge clk);
    mem_ack_i = 1'b1; mem_rdata_i = 32'h1234;
    @(negedge clk);
    mem_ack_i = 1'b0; mem_rdata_i = 32'h0;
    tests_run++; if (cpu_ack_o !== 1'b1) begin tests_failed++; $display("FAIL cpu_ack: got %b want 1", cpu_ack_o); end
    tests_run++; if (cpu_rdata_o !== 32'h1234) begin tests_failed++; $display("FAIL cpu_rdata: got %h want 1234", cpu_rdata_o); end
    tests_run++; if ({mem_req_o, cpu_stall_o} !== 2'b00) begin tests_failed++; $display("FAIL cpu_release: got %b want 00", {mem_req_o, cpu_stall_o}); end
    cpu_req_i = 1'b0;
    @(negedge clk);
    tests_run++; if (cpu_ack_o !== 1'b0) begin tests_failed++; $display("FAIL cpu_ack_pulse: got %b want 0", cpu_ack_o); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_dma_write();
    dma_req_i = 1'b1; dma_we_i = 1'b1; dma_addr_i = 32'h40; dma_wdata_i = 32'hA5A5_A5A5;
    @(negedge clk);
    tests_run++; if ({mem_req_o, mem_we_o} !== 2'b11) begin tests_failed++; $display("FAIL dma_req_we: got %b want 11", {mem_req_o, mem_we_o}); end
    tests_run++; if (mem_addr_o !== 32'h40) begin tests_failed++; $display("FAIL dma_addr: got %h want 40", mem_addr_o); end
    tests_run++; if (mem_wdata_o !== 32'hA5A5_A5A5) begin tests_failed++; $display("FAIL dma_wdata: got %h want a5a5a5a5", mem_wdata_o); end
    mem_ack_i = 1'b1;
    @(negedge clk);
    mem_ack_i = 1'b0;
    tests_run++; if ({dma_ack_o, cpu_ack_o, mem_req_o} !== 3'b100) begin tests_failed++; $display("FAIL dma_ack: got %b want 100", {dma_ack_o, cpu_ack_o, mem_req_o}); end
    dma_req_i = 1'b0; dma_we_i = 1'b0;
    @(negedge clk);
    tests_run++; if (dma_ack_o !== 1'b0) begin tests_failed++; $display("FAIL dma_ack_pulse: got %b want 0", dma_ack_o); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_burst();
    bit exp_d [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    int n = 0;
    cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h100;
    dma_req_i = 1'b1; dma_we_i = 1'b0; dma_addr_i = 32'h200;
    for (int cyc = 0; cyc < 80 && n < 10; cyc++) begin
      @(negedge clk);
      if (cpu_ack_o || dma_ack_o) begin
        tests_run++;
        if ({cpu_ack_o, dma_ack_o} !== (exp_d[n] ? 2'b01 : 2'b10)) begin
          tests_failed++; $display("FAIL burst_order[%0d]: got cpu/dma %b want %b", n, {cpu_ack_o, dma_ack_o}, exp_d[n] ? 2'b01 : 2'b10);
        end
        tests_run++;
        if (exp_d[n] ? (dma_rdata_o !== 32'h201) : (cpu_rdata_o !== 32'h101)) begin
          tests_failed++; $display("FAIL burst_rdata[%0d]: got cpu %h dma %h", n, cpu_rdata_o, dma_rdata_o);
        end
        n++;
        if (n == 10) begin cpu_req_i = 1'b0; dma_req_i = 1'b0; end
      end
      mem_ack_i   = mem_req_o;
      mem_rdata_i = mem_addr_o + 32'h1;
    end
    tests_run++; if (n != 10) begin tests_failed++; $display("FAIL burst_timeout: got %0d acks want 10", n); end
    cpu_req_i = 1'b0; dma_req_i = 1'b0; mem_ack_i = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int stray = 0;
    dma_req_i = 1'b1; dma_we_i = 1'b0; dma_addr_i = 32'h80;
    @(negedge clk);
    tests_run++; if (mem_req_o !== 1'b1) begin tests_failed++; $display("FAIL rstmid_grant: got %b want 1", mem_req_o); end
    #2 rst_i = 1'b0;
    #1;
    tests_run++; if (mem_req_o !== 1'b0) begin tests_failed++; $display("FAIL rstmid_req_drop: got %b want 0", mem_req_o); end
    mem_ack_i = 1'b1; mem_rdata_i = 32'hCAFE;
    @(negedge clk);
    if (dma_ack_o) stray++;
    rst_i = 1'b1; mem_ack_i = 1'b0; dma_req_i = 1'b0;
    tests_run++; if (dma_rdata_o !== 32'h0) begin tests_failed++; $display("FAIL rstmid_rdata: got %h want 0", dma_rdata_o); end
    repeat (3) begin @(negedge clk); if (dma_ack_o) stray++; end
    tests_run++; if (stray != 0) begin tests_failed++; $display("FAIL rstmid_no_ack: got %0d acks want 0", stray); end
    cpu_req_i = 1'b1; cpu_we_i = 1'b1; cpu_addr_i = 32'h44; cpu_wdata_i = 32'h77;
    @(negedge clk);
    tests_run++; if ({mem_req_o, mem_addr_o} !== {1'b1, 32'h44}) begin tests_failed++; $display("FAIL rstmid_idle_regrant: got req %b addr %h want 1 44", mem_req_o, mem_addr_o); end
    mem_ack_i = 1'b1;
    @(negedge clk);
    mem_ack_i = 1'b0;
    tests_run++; if (cpu_ack_o !== 1'b1) begin tests_failed++; $display("FAIL rstmid_cpu_ack: got %b want 1", cpu_ack_o); end
    cpu_req_i = 1'b0; cpu_we_i = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int n = 0, prev = -1, dacks = 0;
    logic [31:0] last_good = 32'h0;
    cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h300;
    mem_ack_i = 1'b1; mem_rdata_i = 32'hBAD0_BAD0;
    for (int cyc = 1; cyc <= 15; cyc++) begin
      @(negedge clk);
      if (dma_ack_o) dacks++;
      if (cpu_ack_o) begin
        tests_run++;
        if (cpu_rdata_o !== last_good) begin tests_failed++; $display("FAIL b2b_rdata[%0d]: got %h want %h", n, cpu_rdata_o, last_good); end
        if (prev >= 0) begin
          tests_run++;
          if (cyc - prev != 4) begin tests_failed++; $display("FAIL b2b_period[%0d]: got %0d want 4", n, cyc - prev); end
        end
        prev = cyc; n++;
      end
      if (mem_req_o) begin
        last_good   = 32'h5000 + 32'(cyc);
        mem_rdata_i = last_good;
      end else begin
        mem_rdata_i = 32'hBAD0_BAD0;
      end
    end
    cpu_req_i = 1'b0; mem_ack_i = 1'b0;
    tests_run++; if (n != 4) begin tests_failed++; $display("FAIL b2b_count: got %0d want 4", n); end
    tests_run++; if (dacks != 0) begin tests_failed++; $display("FAIL b2b_dma_ack: got %0d want 0", dacks); end
    repeat (3) @(negedge clk);
  endtask

`ifdef DMEM_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int early = 0;
    cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h500; mem_ack_i = 1'b0;
    for (int i = 1; i <= 7; i++) begin @(negedge clk); if (cpu_ack_o) early++; end
    tests_run++; if (early != 0) begin tests_failed++; $display("FAIL to_early_ack: got %0d want 0", early); end
    @(negedge clk);
    tests_run++; if ({cpu_ack_o, err_o, mem_req_o} !== 3'b110) begin tests_failed++; $display("FAIL to_ack_err: got %b want 110", {cpu_ack_o, err_o, mem_req_o}); end
    tests_run++; if (cpu_rdata_o !== 32'hDEAD_BEEF) begin tests_failed++; $display("FAIL to_rdata: got %h want deadbeef", cpu_rdata_o); end
    cpu_req_i = 1'b0;
    repeat (4) @(negedge clk);
    tests_run++; if (err_o !== 1'b1) begin tests_failed++; $display("FAIL to_sticky: got %b want 1", err_o); end
  endtask
`endif

  initial begin
    test_reset();
    test_cpu_read();
    test_dma_write();
    test_burst();
    test_reset_mid();
    test_back_to_back();
`ifdef DMEM_ARB_TIMEOUT_EN
    test_timeout();
`else
    tests_run++; if (err_o !== 1'b0) begin tests_failed++; $display("FAIL err_tied: got %b want 0", err_o); end
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
